// File: rtl/rotary_emu.sv
// rotary_emu: quadrature rotary-encoder emulator driving Rot_A/Rot_B detents and Rot_C push pulses.
// Optional macro EXP_MODEL_EN adds Exp_Count, the count a downstream decoder should hold.
module rotary_emu #(
  parameter int PHASE_CYCLES = 24000,
  parameter int GAP_CYCLES   = 48000
) (
  input  logic       Fg_CLK,
  input  logic       RESET,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic       Cmd_Dir,
  input  logic [7:0] Cmd_Steps,
  input  logic       Cmd_Push,
  output logic       Rot_A,
  output logic       Rot_B,
  output logic       Rot_C,
  output logic       Busy,
  output logic       Done
`ifdef EXP_MODEL_EN
  ,
  output logic [11:0] Exp_Count
`endif
);
  typedef enum logic [2:0] {IDLE, PUSH, PGAP, PH1, PH2, PH3, PH4, SGAP} state_t;
  localparam logic [21:0] PH_LD  = 22'(PHASE_CYCLES - 1);
  localparam logic [21:0] GAP_LD = 22'(GAP_CYCLES - 1);
  state_t      r_state, w_next;
  logic [21:0] r_timer, w_ld;
  logic [7:0]  r_steps;
  logic        r_dir, w_dir, w_exp, w_x, w_y;
  assign w_exp = r_timer == 22'd0;
  assign w_dir = (r_state == IDLE) ? Cmd_Dir : r_dir;
  // Plus-direction levels of (A,B) for the next state; minus swaps the roles.
  assign w_x = !(w_next == PH2 || w_next == PH3);
  assign w_y = !(w_next == PH1 || w_next == PH2);
  always_comb begin
    w_next = r_state;
    w_ld   = r_timer - 22'd1;
    case (r_state)
      IDLE: begin
        w_ld = 22'd0;
        if (Cmd_Valid) begin
          w_next = Cmd_Push ? PUSH : (Cmd_Steps != 8'd0 ? PH1 : PGAP);
          w_ld   = (!Cmd_Push && Cmd_Steps != 8'd0) ? PH_LD : 22'd0;
        end
      end
      PUSH: begin
        w_next = PGAP;
        w_ld   = GAP_LD;
      end
      PGAP: if (w_exp) begin
        w_next = (r_steps != 8'd0) ? PH1 : IDLE;
        w_ld   = (r_steps != 8'd0) ? PH_LD : 22'd0;
      end
      PH1: if (w_exp) begin
        w_next = PH2;
        w_ld   = PH_LD;
      end
      PH2: if (w_exp) begin
        w_next = PH3;
        w_ld   = PH_LD;
      end
      PH3: if (w_exp) begin
        w_next = PH4;
        w_ld   = PH_LD;
      end
      PH4: if (w_exp) begin
        w_next = SGAP;
        w_ld   = GAP_LD;
      end
      SGAP: if (w_exp) begin
        w_next = (r_steps != 8'd1) ? PH1 : IDLE;
        w_ld   = (r_steps != 8'd1) ? PH_LD : 22'd0;
      end
      default: begin
        w_next = IDLE;
        w_ld   = 22'd0;
      end
    endcase
  end
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_timer   <= 22'd0;
      r_steps   <= 8'd0;
      r_dir     <= 1'b0;
      Rot_A     <= 1'b1;
      Rot_B     <= 1'b1;
      Rot_C     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Cmd_Ready <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_ld;
      r_dir     <= w_dir;
      r_steps   <= (r_state == IDLE) ? Cmd_Steps : (r_state == SGAP && w_exp) ? r_steps - 8'd1 : r_steps;
      Rot_A     <= w_dir ? w_x : w_y;
      Rot_B     <= w_dir ? w_y : w_x;
      Rot_C     <= w_next == PUSH;
      Busy      <= w_next != IDLE;
      Cmd_Ready <= w_next == IDLE;
      Done      <= r_state != IDLE && w_next == IDLE;
    end
  end
`ifdef EXP_MODEL_EN
  logic [1:0]  r_step_exp;
  logic [11:0] w_inc;
  assign w_inc = (r_step_exp == 2'd0) ? 12'd1 : (r_step_exp == 2'd1) ? 12'd10 : 12'd100;
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_step_exp <= 2'd0;
      Exp_Count  <= 12'd0;
    end else begin
      if (r_state == PUSH) r_step_exp <= (r_step_exp == 2'd2) ? 2'd0 : r_step_exp + 2'd1;
      if (r_state == PH4 && w_exp)
        Exp_Count <= r_dir ? ((Exp_Count + w_inc > 12'd1800) ? 12'd1800 : Exp_Count + w_inc)
                           : ((Exp_Count < w_inc) ? 12'd0 : Exp_Count - w_inc);
    end
  end
`endif
endmodule

// File: tb/tb_rotary_emu.sv
// tb_rotary_emu: directed bench for rotary_emu; a waveform-queue model predicts every output cycle.
module tb_rotary_emu;
  localparam int PH = 4;
  localparam int GP = 8;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, dir = 1'b0, push = 1'b0;
  logic [7:0] steps = 8'd0;
  logic ready, rot_a, rot_b, rot_c, busy, done;
  logic [11:0] exp_cnt;
  int total = 0, bad = 0;
  rotary_emu #(.PHASE_CYCLES(PH), .GAP_CYCLES(GP)) dut (
    .Fg_CLK(clk), .RESET(rst), .Cmd_Valid(valid), .Cmd_Ready(ready), .Cmd_Dir(dir),
    .Cmd_Steps(steps), .Cmd_Push(push), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_C(rot_c),
    .Busy(busy), .Done(done)
`ifdef EXP_MODEL_EN
    , .Exp_Count(exp_cnt)
`endif
  );
`ifndef EXP_MODEL_EN
  assign exp_cnt = 12'd0;
`endif
  always #5 clk = ~clk;
  typedef struct packed {logic a, b, c, busy, done, ready; logic [11:0] cnt;} vec_t;
  vec_t q[$];
  vec_t cur;
  int m_cnt = 0, m_sexp = 0;
  function automatic vec_t mk(logic a, logic b, logic c, logic bz, logic dn, logic rd);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.busy = bz; v.done = dn; v.ready = rd; v.cnt = 12'(m_cnt);
    return v;
  endfunction
  task automatic add(input int n, input logic a, input logic b, input logic c);
    for (int i = 0; i < n; i++) q.push_back(mk(a, b, c, 1'b1, 1'b0, 1'b0));
  endtask
  // The leading line is low for the first two phases, the lagging one for the middle two.
  task automatic build(input logic d, input int n, input logic p);
    int inc;
    logic lead_lo, lag_lo;
    if (p) begin
      add(1, 1'b1, 1'b1, 1'b1);
      add(GP, 1'b1, 1'b1, 1'b0);
      m_sexp = (m_sexp + 1) % 3;
    end
    inc = m_sexp == 0 ? 1 : m_sexp == 1 ? 10 : 100;
    for (int s = 0; s < n; s++) begin
      for (int ph = 0; ph < 4; ph++) begin
        lead_lo = ph < 2;
        lag_lo  = ph == 1 || ph == 2;
        add(PH, d ? !lag_lo : !lead_lo, d ? !lead_lo : !lag_lo, 1'b0);
      end
      m_cnt = d ? (m_cnt + inc > 1800 ? 1800 : m_cnt + inc) : (m_cnt < inc ? 0 : m_cnt - inc);
      add(GP, 1'b1, 1'b1, 1'b0);
    end
    if (!p && n == 0) add(1, 1'b1, 1'b1, 1'b0);
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask
  initial cur = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_sexp = 0;
      cur = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      if (valid && cur.ready) build(dir, int'(steps), push);
      cur = (q.size() != 0) ? q.pop_front() : mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    #1;
    total++;
    if ({rot_a, rot_b, rot_c, busy, done, ready} !== {cur.a, cur.b, cur.c, cur.busy, cur.done, cur.ready}) begin
      bad++;
      $display("FAIL outs t=%0t got ABC/busy/done/rdy=%b exp=%b", $time,
               {rot_a, rot_b, rot_c, busy, done, ready}, {cur.a, cur.b, cur.c, cur.busy, cur.done, cur.ready});
    end
`ifdef EXP_MODEL_EN
    total++;
    if (exp_cnt !== cur.cnt) begin
      bad++;
      $display("FAIL exp_count t=%0t got=%0d exp=%0d", $time, exp_cnt, cur.cnt);
    end
`endif
  end
  int cyc = 0, a_fall, b_fall, a_rise, b_rise, fa, fb, done_c, done_n, c_n, tog;
  logic pa = 1'b1, pb = 1'b1;
  task automatic clr();
    a_fall = -1; b_fall = -1; a_rise = -1; b_rise = -1; fa = -1; fb = -1;
    done_c = -1; done_n = 0; c_n = 0; tog = 0;
  endtask
  always @(posedge clk) begin
    cyc++;
    #2;
    if (pa && !rot_a) begin a_fall = cyc; if (fa < 0) fa = cyc; end
    if (pb && !rot_b) begin b_fall = cyc; if (fb < 0) fb = cyc; end
    if (!pa && rot_a) a_rise = cyc;
    if (!pb && rot_b) b_rise = cyc;
    if (rot_a !== pa || rot_b !== pb) tog++;
    if (rot_c) c_n++;
    if (done) begin done_n++; done_c = cyc; end
    pa = rot_a;
    pb = rot_b;
  end
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic cmd(input logic d, input int n, input logic p);
    valid = 1'b1; dir = d; steps = 8'(n); push = p;
    @(negedge clk);
    valid = 1'b0; dir = 1'b0; steps = 8'd0; push = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = done;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL done_timeout budget=%0d", budget);
    end
  endtask
  int t0;
  initial begin
    clr();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_ready", int'(ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ab", int'({rot_a, rot_b, rot_c}), 3'b110);
    clr();
    cmd(1'b1, 1, 1'b0);
    wait_done(60);
    chk("p1_a_after_b", a_fall - b_fall, 4);
    chk("p1_b_rise", b_rise - b_fall, 8);
    chk("p1_a_rise", a_rise - b_fall, 12);
    chk("p1_done", done_c - b_fall, 24);
`ifdef EXP_MODEL_EN
    chk("p1_cnt", int'(exp_cnt), 1);
`endif
    cmd(1'b1, 1, 1'b0);
    wait_done(60);
    clr();
    cmd(1'b0, 3, 1'b0);
    wait_done(120);
    chk("m3_a_leads", int'(fa < fb), 1);
    chk("m3_a_lead_gap", fb - fa, 4);
    chk("m3_span", done_c - fa, 72);
    chk("m3_one_done", done_n, 1);
`ifdef EXP_MODEL_EN
    chk("m3_cnt_sat0", int'(exp_cnt), 0);
`endif
    clr();
    cmd(1'b0, 0, 1'b1);
    wait_done(30);
    cmd(1'b0, 0, 1'b1);
    wait_done(30);
    cmd(1'b1, 2, 1'b0);
    wait_done(100);
    chk("push_pulses", c_n, 2);
`ifdef EXP_MODEL_EN
    chk("push_cnt200", int'(exp_cnt), 200);
`endif
    repeat (2) @(negedge clk);
    clr();
    t0 = cyc;
    cmd(1'b0, 0, 1'b0);
    wait_done(5);
    chk("noop_lat", done_c - t0, 2);
    chk("noop_tog", tog, 0);
    chk("noop_c", c_n, 0);
    cmd(1'b1, 1, 1'b0);
    chk("b2b_ph1", int'({rot_a, rot_b, busy}), 3'b101);
    wait_done(60);
    clr();
    cmd(1'b1, 5, 1'b0);
    for (int i = 0; i < 20 && (rot_a || rot_b); i++) @(negedge clk);
    chk("rst_in_ph2", int'({rot_a, rot_b}), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ab", int'({rot_a, rot_b, rot_c, busy}), 4'b1100);
    repeat (30) @(negedge clk);
    chk("rst_no_done", done_n, 0);
    clr();
    cmd(1'b1, 1, 1'b0);
    wait_done(60);
    chk("post_rst_done", done_n, 1);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
